// File: rtl/restoring_divider_32_by_16_if.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider_32_by_16_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface restoring_divider_32_by_16_if #(
    parameter int N = 16
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/restoring_divider_32_by_16.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider_32_by_16
// Description : Unsigned 2N-by-N restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider_32_by_16 #(
    parameter int N = 16
) (
    input  wire                          clk,
    input  wire                          rst_n,
    restoring_divider_32_by_16_if.slave  bus
);
    localparam int            c_CW   = $clog2(2*N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(2*N-1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_CALC = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [c_CW-1:0] r_count;
    logic [2*N-1:0]  r_shift;
    logic [N:0]      r_partial;
    logic [N-1:0]    r_divisor;
    logic [2*N-1:0]  r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_dbz;
    logic            r_done;
    logic            w_busy;
    logic            w_last;

    // Shifted partial is N+2 wide so the trial result's top bit is a clean sign.
    logic [N+1:0]    w_sh_full;
    logic [N+1:0]    w_trial;
    logic            w_neg;
    logic [N:0]      w_next_partial;
    logic [2*N-1:0]  w_next_shift;

    assign w_sh_full      = {r_partial, r_shift[2*N-1]};
    assign w_trial        = w_sh_full - {2'b00, r_divisor};
    assign w_neg          = w_trial[N+1];
    assign w_next_partial = w_neg ? w_sh_full[N:0] : w_trial[N:0];
    assign w_next_shift   = {r_shift[2*N-2:0], ~w_neg};
    assign w_last         = (r_count == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (bus.start && (bus.divisor != '0)) w_state_next = c_CALC;
            c_CALC: if (w_last) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == c_CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_shift     <= '0;
            r_partial   <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            r_shift   <= bus.dividend;
                            r_partial <= '0;
                            r_count   <= '0;
                            r_divisor <= bus.divisor;
                            r_dbz     <= 1'b0;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend[N-1:0];
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                        end
                    end
                end
                c_CALC: begin
                    r_shift   <= w_next_shift;
                    r_partial <= w_next_partial;
                    r_count   <= r_count + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_next_shift;
                        r_remainder <= w_next_partial[N-1:0];
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire
